// File: rtl/alu_parity_pipe.sv
// alu_parity_pipe: three-stage encode / ALU / parity pipeline
// with valid/ready flow control and bubble collapsing.
module alu_parity_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       func_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       op_code,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             parity,
    output logic             err
);

    logic             v1, v2, v3;
    logic             rdy1, rdy2, rdy3;

    logic [2:0]       op1, op2, op3;
    logic             err1, err2, err3;
    logic [WIDTH-1:0] a1, b1;
    logic [WIDTH-1:0] res2, res3;
    logic             cy2, cy3;
    logic             par3;

    logic [2:0]       enc_op;
    logic             enc_err;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cy;

    // A stage can take new data when empty or when it drains this cycle
    always_comb begin
        rdy3 = !v3 || out_ready;
        rdy2 = !v2 || rdy3;
        rdy1 = !v1 || rdy2;
    end

    assign in_ready = rdy1;

    // One-hot to binary encode; anything not exactly one-hot is an error
    always_comb begin
        enc_op[0] = func_code[1] | func_code[3] | func_code[5] | func_code[7];
        enc_op[1] = func_code[2] | func_code[3] | func_code[6] | func_code[7];
        enc_op[2] = func_code[4] | func_code[5] | func_code[6] | func_code[7];
        enc_err   = (func_code == 8'd0) ||
                    ((func_code & (func_code - 8'd1)) != 8'd0);
    end

    // ALU on stage-1 operands; error ops yield zero result and carry
    always_comb begin
        sum     = {1'b0, a1} + {1'b0, b1};
        diff    = a1 - b1;
        alu_res = '0;
        alu_cy  = 1'b0;
        case (op1)
            3'd0: begin alu_res = sum[WIDTH-1:0]; alu_cy = sum[WIDTH]; end
            3'd1: begin alu_res = diff; alu_cy = (a1 < b1); end
            3'd2: alu_res = a1 ^ b1;
            3'd3: alu_res = a1 | b1;
            3'd4: alu_res = a1 & b1;
            3'd5: alu_res = ~(a1 | b1);
            3'd6: alu_res = ~(a1 & b1);
            3'd7: alu_res = ~(a1 ^ b1);
            default: alu_res = '0;
        endcase
        if (err1) begin
            alu_res = '0;
            alu_cy  = 1'b0;
        end
    end

    // Stage 1: capture encoded op and operands
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            op1  <= '0;
            err1 <= 1'b0;
            a1   <= '0;
            b1   <= '0;
        end else if (rdy1) begin
            v1 <= in_valid;
            if (in_valid) begin
                op1  <= enc_op;
                err1 <= enc_err;
                a1   <= a;
                b1   <= b;
            end
        end
    end

    // Stage 2: capture ALU result
    always_ff @(posedge clk) begin
        if (rst) begin
            v2   <= 1'b0;
            op2  <= '0;
            err2 <= 1'b0;
            res2 <= '0;
            cy2  <= 1'b0;
        end else if (rdy2) begin
            v2 <= v1;
            if (v1) begin
                op2  <= op1;
                err2 <= err1;
                res2 <= alu_res;
                cy2  <= alu_cy;
            end
        end
    end

    // Stage 3: capture result with its even-parity bit
    always_ff @(posedge clk) begin
        if (rst) begin
            v3   <= 1'b0;
            op3  <= '0;
            err3 <= 1'b0;
            res3 <= '0;
            cy3  <= 1'b0;
            par3 <= 1'b0;
        end else if (rdy3) begin
            v3 <= v2;
            if (v2) begin
                op3  <= op2;
                err3 <= err2;
                res3 <= res2;
                cy3  <= cy2;
                par3 <= ^res2;
            end
        end
    end

    assign out_valid = v3;
    assign op_code   = op3;
    assign result    = res3;
    assign carry     = cy3;
    assign parity    = par3;
    assign err       = err3;

endmodule
